// File: rtl/resize_result_writer.sv
// Result-memory writer behind the bilinear interpolator: FIFO-buffered raster writes with stall, DONE and OVERFLOW.
// Optional RESIZE_CHECKSUM_EN adds a 16-bit running sum of written pixels on CHECKSUM.
module resize_result_writer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              START,
  input  logic [5:0]        OUT_W_M1,
  input  logic [5:0]        OUT_H_M1,
  input  logic              O_VALID,
  input  logic [DATA_W-1:0] O_DATA,
  input  logic              MEM_BUSY,
  output logic              WEN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [DATA_W-1:0] W_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW
`ifdef RESIZE_CHECKSUM_EN
  ,
  output logic [15:0]       CHECKSUM
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t              state_r, state_next_s;
  logic [DATA_W-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]      count_r;
  logic [5:0]          w_m1_r, h_m1_r, row_r, col_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wen_r, busy_r, done_r, overflow_r;
  logic [ADDR_W-1:0]   w_addr_r;
  logic [DATA_W-1:0]   w_data_r;

  logic                collect_s, empty_s, full_s;
  logic                push_s, pop_s, push_ok_s, drop_s, last_s;
  logic [DATA_W-1:0]   head_s;

  // Handshake decode and next-state logic; START overrides any push/pop in its cycle.
  always_comb begin
    collect_s    = (state_r == S_COLLECT);
    empty_s      = (count_r == '0);
    full_s       = (count_r == FULL_CNT);
    head_s       = fifo_mem_r[rd_ptr_r];
    pop_s        = collect_s && !empty_s && !MEM_BUSY && !START;
    push_s       = collect_s && O_VALID && !START;
    push_ok_s    = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    last_s       = (row_r == h_m1_r) && (col_r == w_m1_r);
    state_next_s = state_r;
    if (START) begin
      state_next_s = S_COLLECT;
    end else if (pop_s && last_s) begin
      state_next_s = S_DONE;
    end else begin
      state_next_s = state_r;
    end
  end

  // State register with registered BUSY decode.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == S_COLLECT);
    end
  end

  // Pixel FIFO storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= O_DATA;
    end
  end

  // FIFO pointers and occupancy; the final write discards whatever is left.
  always_ff @(posedge clk) begin
    if (RST || START || (pop_s && last_s)) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)     rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Write port, raster address walk and frame status.
  always_ff @(posedge clk) begin
    if (RST) begin
      w_m1_r     <= 6'd0;
      h_m1_r     <= 6'd0;
      row_r      <= 6'd0;
      col_r      <= 6'd0;
      addr_r     <= '0;
      wen_r      <= 1'b1;
      w_addr_r   <= '0;
      w_data_r   <= '0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else if (START) begin
      w_m1_r     <= OUT_W_M1;
      h_m1_r     <= OUT_H_M1;
      row_r      <= 6'd0;
      col_r      <= 6'd0;
      addr_r     <= '0;
      wen_r      <= 1'b1;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (drop_s) overflow_r <= 1'b1;
      if (pop_s) begin
        wen_r    <= 1'b0;
        w_addr_r <= addr_r;
        w_data_r <= head_s;
        addr_r   <= addr_r + 1'b1;
        if (last_s) begin
          done_r <= 1'b1;
        end else if (col_r == w_m1_r) begin
          col_r <= 6'd0;
          row_r <= row_r + 1'b1;
        end else begin
          col_r <= col_r + 1'b1;
        end
      end else begin
        wen_r <= 1'b1;
      end
    end
  end

`ifdef RESIZE_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Running modulo-2^16 sum of every pixel sent to memory.
  always_ff @(posedge clk) begin
    if (RST || START) begin
      checksum_r <= 16'd0;
    end else if (pop_s) begin
      checksum_r <= checksum_r + 16'(head_s);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign CHECKSUM = checksum_r;
`endif

  assign WEN      = wen_r;
  assign W_ADDR   = w_addr_r;
  assign W_DATA   = w_data_r;
  assign BUSY     = busy_r;
  assign DONE     = done_r;
  assign OVERFLOW = overflow_r;

endmodule

// File: tb/tb_resize_result_writer.sv
// Directed self-checking bench for resize_result_writer (default parameters).
module tb_resize_result_writer;
  logic        clk = 1'b0;
  logic        RST, START, O_VALID, MEM_BUSY;
  logic [5:0]  OUT_W_M1, OUT_H_M1;
  logic [7:0]  O_DATA;
  logic        WEN, BUSY, DONE, OVERFLOW;
  logic [11:0] W_ADDR;
  logic [7:0]  W_DATA;
`ifdef RESIZE_CHECKSUM_EN
  logic [15:0] CHECKSUM;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  resize_result_writer #(.DATA_W(8), .ADDR_W(12), .FIFO_DEPTH(4)) dut (
    .clk(clk), .RST(RST), .START(START), .OUT_W_M1(OUT_W_M1), .OUT_H_M1(OUT_H_M1),
    .O_VALID(O_VALID), .O_DATA(O_DATA), .MEM_BUSY(MEM_BUSY),
    .WEN(WEN), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .BUSY(BUSY), .DONE(DONE),
    .OVERFLOW(OVERFLOW)
`ifdef RESIZE_CHECKSUM_EN
    , .CHECKSUM(CHECKSUM)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_write(input string tag, input int addr, input int data);
    chk({tag, "_wen"}, {31'd0, WEN}, 32'd0);
    chk({tag, "_addr"}, {20'd0, W_ADDR}, addr);
    chk({tag, "_data"}, {24'd0, W_DATA}, data);
  endtask

  task automatic begin_frame(input logic [5:0] wm1, input logic [5:0] hm1);
    OUT_W_M1 = wm1; OUT_H_M1 = hm1; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  initial begin
    int bad;
    RST = 1'b1; START = 1'b0; O_VALID = 1'b0; O_DATA = 8'd0; MEM_BUSY = 1'b0;
    OUT_W_M1 = 6'd0; OUT_H_M1 = 6'd0;
    tick(); tick();
    chk("rst_wen", {31'd0, WEN}, 32'd1);
    chk("rst_addr", {20'd0, W_ADDR}, 32'd0);
    chk("rst_data", {24'd0, W_DATA}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    RST = 1'b0;

    // 2x2 frame, one edge latency per pixel
    begin_frame(6'd1, 6'd1);
    chk("f1_busy", {31'd0, BUSY}, 32'd1);
    O_VALID = 1'b1; O_DATA = 8'd10; tick();
    chk("f1_no_bypass", {31'd0, WEN}, 32'd1);
    O_DATA = 8'd20; tick(); expect_write("f1_p0", 0, 10);
    O_DATA = 8'd30; tick(); expect_write("f1_p1", 1, 20);
    O_DATA = 8'd40; tick(); expect_write("f1_p2", 2, 30);
    chk("f1_done_early", {31'd0, DONE}, 32'd0);
    O_VALID = 1'b0; tick(); expect_write("f1_p3", 3, 40);
    chk("f1_done", {31'd0, DONE}, 32'd1);
    chk("f1_busy_end", {31'd0, BUSY}, 32'd0);
    tick();
    chk("f1_wen_idle", {31'd0, WEN}, 32'd1);
    chk("f1_done_hold", {31'd0, DONE}, 32'd1);

    // 3x2 frame, then a stray pixel while in DONE
    begin_frame(6'd2, 6'd1);
    chk("f2_done_clr", {31'd0, DONE}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      O_VALID = 1'b1; O_DATA = 8'(i + 1); tick();
      if (i > 0) expect_write("f2_px", i - 1, i);
    end
    O_VALID = 1'b0; tick(); expect_write("f2_p5", 5, 6);
    chk("f2_done", {31'd0, DONE}, 32'd1);
    O_VALID = 1'b1; O_DATA = 8'd99; tick();
    chk("f2_stray_wen", {31'd0, WEN}, 32'd1);
    O_VALID = 1'b0; tick();
    chk("f2_stray_wen2", {31'd0, WEN}, 32'd1);
    chk("f2_stray_ovf", {31'd0, OVERFLOW}, 32'd0);

    // Stall with overflow: depth 4, six pushes
    begin_frame(6'd1, 6'd1);
    MEM_BUSY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      O_VALID = 1'b1; O_DATA = 8'(i + 1); tick();
      chk("f3_stall_wen", {31'd0, WEN}, 32'd1);
      if (i == 3) chk("f3_ovf_not_yet", {31'd0, OVERFLOW}, 32'd0);
    end
    chk("f3_ovf", {31'd0, OVERFLOW}, 32'd1);
    O_VALID = 1'b0; MEM_BUSY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_write("f3_drain", i, i + 1);
    end
    chk("f3_done", {31'd0, DONE}, 32'd1);
    chk("f3_ovf_sticky", {31'd0, OVERFLOW}, 32'd1);

    // Mid-frame restart with a colliding pixel
    begin_frame(6'd3, 6'd3);
    chk("f4_ovf_clr", {31'd0, OVERFLOW}, 32'd0);
    MEM_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      O_VALID = 1'b1; O_DATA = 8'(7 + i); tick();
    end
    START = 1'b1; O_DATA = 8'd55; tick();
    START = 1'b0; MEM_BUSY = 1'b0;
    chk("f4_restart_wen", {31'd0, WEN}, 32'd1);
    chk("f4_restart_done", {31'd0, DONE}, 32'd0);
    O_DATA = 8'd66; tick();
    chk("f4_flushed", {31'd0, WEN}, 32'd1);
    O_VALID = 1'b0; tick(); expect_write("f4_first", 0, 66);
    tick();
    chk("f4_no_stale", {31'd0, WEN}, 32'd1);

    // Full 64x64 raster sweep
    begin_frame(6'd63, 6'd63);
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      O_VALID = 1'b1; O_DATA = 8'(i); tick();
      if (i > 0 && (WEN !== 1'b0 || W_ADDR !== 12'(i - 1) || W_DATA !== 8'(i - 1))) bad++;
    end
    chk("f5_sweep", bad, 32'd0);
    O_VALID = 1'b0; tick(); expect_write("f5_last", 4095, 255);
    chk("f5_done", {31'd0, DONE}, 32'd1);

`ifdef RESIZE_CHECKSUM_EN
    begin_frame(6'd2, 6'd0);
    chk("cs_clear", {16'd0, CHECKSUM}, 32'd0);
    O_VALID = 1'b1; O_DATA = 8'd255; tick();
    tick();
    O_DATA = 8'd1; tick();
    O_VALID = 1'b0; tick();
    chk("cs_sum", {16'd0, CHECKSUM}, 32'd511);
    chk("cs_done", {31'd0, DONE}, 32'd1);
    begin_frame(6'd2, 6'd0);
    chk("cs_restart", {16'd0, CHECKSUM}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
